// File: rtl/acumulador_pkg.sv
// Shared command codes and FSM encodings for the parameterised accumulator.
package acumulador_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
  localparam logic [OP_W-1:0] OP_LOAD = 3'd1;
  localparam logic [OP_W-1:0] OP_CLR  = 3'd2;
  localparam logic [OP_W-1:0] OP_INC  = 3'd3;
  localparam logic [OP_W-1:0] OP_DEC  = 3'd4;
  localparam logic [OP_W-1:0] OP_SHL  = 3'd5;
  localparam logic [OP_W-1:0] OP_SHR  = 3'd6;
  localparam logic [OP_W-1:0] OP_ROTN = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ROT  = 1'b1
  } state_t;

endpackage

// File: rtl/acumulador_param.sv
// Accumulator: single-cycle load/clr/inc/dec/shift, multi-cycle rotate-left (ROTN) with busy/done.
// Ops 0-6 land on the accepting edge; ROTN holds busy for amt cycles and commands arriving while busy are dropped.
module acumulador_param
  import acumulador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             n_write,
  input  logic [OP_W-1:0]  op,
  input  logic             si,
  input  logic [CNT_W-1:0] amt,
  input  logic             ea,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             neg,
  output logic             carry
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic             accept;

  assign accept  = !n_write && !busy;
  assign alu_out = acc;
  assign bus_out = ea ? acc : {WIDTH{1'bz}};
  assign zero    = (acc == '0);
  assign neg     = acc[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_NOP: ;
              OP_LOAD: begin
                acc   <= d;
                carry <= 1'b0;
              end
              OP_CLR: begin
                acc   <= '0;
                carry <= 1'b0;
              end
              OP_INC: begin
                acc   <= acc + ONE;
                carry <= (acc == '1);
              end
              OP_DEC: begin
                acc   <= acc - ONE;
                carry <= (acc == '0);
              end
              OP_SHL: begin
                acc   <= {acc[WIDTH-2:0], si};
                carry <= acc[WIDTH-1];
              end
              OP_SHR: begin
                acc   <= {si, acc[WIDTH-1:1]};
                carry <= acc[0];
              end
              OP_ROTN: begin
                // Zero-length rotate completes at once with only the done pulse.
                if (amt == CNT_ZERO) begin
                  done <= 1'b1;
                end else begin
                  cnt   <= amt;
                  state <= ST_ROT;
                  busy  <= 1'b1;
                end
              end
            endcase
          end
        end
        ST_ROT: begin
          acc   <= {acc[WIDTH-2:0], acc[WIDTH-1]};
          carry <= acc[WIDTH-1];
          cnt   <= cnt - CNT_ONE;
          // Last rotation step: leave ROT so busy spans exactly amt cycles.
          if (cnt == CNT_ONE) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acumulador_param.sv
// Randomised and directed bench for acumulador_param (WIDTH=8) against an arithmetic reference model.
module tb_acumulador_param;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  d;
  logic          n_write;
  logic [2:0]    op;
  logic          si;
  logic [CW-1:0] amt;
  logic          ea;
  logic [W-1:0]  bus_out;
  logic [W-1:0]  alu_out;
  logic          busy;
  logic          done;
  logic          zero;
  logic          neg;
  logic          carry;

  acumulador_param #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .d(d), .n_write(n_write), .op(op), .si(si),
    .amt(amt), .ea(ea), .bus_out(bus_out), .alu_out(alu_out), .busy(busy),
    .done(done), .zero(zero), .neg(neg), .carry(carry)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: accumulator value, carry, rotations still owed, done flag.
  int m_acc   = 0;
  int m_carry = 0;
  int m_left  = 0;
  int m_done  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_acc = 0; m_carry = 0; m_left = 0; m_done = 0;
  endfunction

  function automatic void model_edge();
    int nd;
    nd = 0;
    if (m_left > 0) begin
      m_carry = (m_acc >> 7) & 1;
      m_acc   = ((m_acc << 1) | (m_acc >> 7)) & 255;
      m_left  = m_left - 1;
      if (m_left == 0) nd = 1;
    end else if (!n_write) begin
      case (int'(op))
        1: begin m_acc = int'(d); m_carry = 0; end
        2: begin m_acc = 0; m_carry = 0; end
        3: begin m_carry = (m_acc == 255); m_acc = (m_acc + 1) % 256; end
        4: begin m_carry = (m_acc == 0); m_acc = (m_acc + 255) % 256; end
        5: begin m_carry = (m_acc >> 7) & 1; m_acc = ((m_acc << 1) | int'(si)) & 255; end
        6: begin m_carry = m_acc & 1; m_acc = (m_acc >> 1) | (int'(si) << 7); end
        7: begin if (amt == 0) nd = 1; else m_left = int'(amt); end
        default: ;
      endcase
    end
    m_done = nd;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_alu"},   alu_out, m_acc);
    check({tag, "_carry"}, carry,   m_carry);
    check({tag, "_zero"},  zero,    (m_acc == 0));
    check({tag, "_neg"},   neg,     (m_acc >> 7) & 1);
    check({tag, "_busy"},  busy,    (m_left > 0));
    check({tag, "_done"},  done,    m_done);
    if (ea) check({tag, "_bus"}, bus_out, m_acc);
    else if (m_acc != 0) check({tag, "_bus_rel"}, (bus_out !== alu_out), 1);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] dv, input logic [2:0] a,
                       input logic s, input string tag);
    n_write = 1'b0; op = o; d = dv; amt = a; si = s;
    step(tag);
    n_write = 1'b1;
  endtask

  int bc, dc;

  initial begin
    rst = 1'b1; d = '0; n_write = 1'b1; op = '0; si = 1'b0; amt = '0; ea = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_alu", alu_out, 0);
    check("rst_zero", zero, 1);
    check("rst_neg", neg, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_carry", carry, 0);
    rst = 1'b0;

    // Load and bus enable
    ea = 1'b1;
    issue(3'd1, 8'hA5, 3'd0, 1'b0, "load");
    check("load_bus", bus_out, 8'hA5);
    check("load_alu", alu_out, 8'hA5);
    check("load_neg", neg, 1);
    check("load_zero", zero, 0);
    ea = 1'b0;
    #1;
    check("bus_released", (bus_out !== 8'hA5), 1);
    check("alu_hold", alu_out, 8'hA5);

    // INC/DEC wrap
    issue(3'd1, 8'hFF, 3'd0, 1'b0, "load_ff");
    issue(3'd3, 8'h00, 3'd0, 1'b0, "inc");
    check("inc_wrap", alu_out, 8'h00);
    check("inc_carry", carry, 1);
    check("inc_zero", zero, 1);
    issue(3'd4, 8'h00, 3'd0, 1'b0, "dec");
    check("dec_wrap", alu_out, 8'hFF);
    check("dec_borrow", carry, 1);

    // Shifts
    issue(3'd1, 8'h81, 3'd0, 1'b0, "load_81");
    issue(3'd5, 8'h00, 3'd0, 1'b0, "shl");
    check("shl_val", alu_out, 8'h02);
    check("shl_carry", carry, 1);
    issue(3'd6, 8'h00, 3'd0, 1'b1, "shr");
    check("shr_val", alu_out, 8'h81);
    check("shr_carry", carry, 0);

    // ROTN amt=3 with a LOAD attempted while busy
    issue(3'd1, 8'h01, 3'd0, 1'b0, "load_01");
    issue(3'd7, 8'h00, 3'd3, 1'b0, "rot3");
    bc = int'(busy); dc = int'(done);
    repeat (2) begin
      n_write = 1'b0; op = 3'd1; d = 8'hFF;
      step("rot3_run");
      bc += int'(busy); dc += int'(done);
    end
    n_write = 1'b1;
    repeat (4) begin
      step("rot3_tail");
      bc += int'(busy); dc += int'(done);
    end
    check("rot3_busy_cycles", bc, 3);
    check("rot3_done_pulses", dc, 1);
    check("rot3_val", alu_out, 8'h08);

    // ROTN amt=0
    issue(3'd7, 8'h00, 3'd0, 1'b0, "rot0");
    check("rot0_busy", busy, 0);
    check("rot0_done", done, 1);
    check("rot0_val", alu_out, 8'h08);
    step("rot0_after");
    check("rot0_done_clear", done, 0);

    // ROTN amt=5 aborted by reset
    issue(3'd1, 8'h5A, 3'd0, 1'b0, "load_5a");
    issue(3'd7, 8'h00, 3'd5, 1'b0, "rot5");
    step("rot5_run");
    step("rot5_run");
    rst = 1'b1;
    #1;
    model_reset();
    check("abort_acc", alu_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(posedge clk);
    #1;
    check_all("abort_hold");
    rst = 1'b0;
    dc = 0;
    repeat (6) begin
      step("abort_after");
      dc += int'(done);
    end
    check("abort_no_done", dc, 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      n_write = ($urandom_range(0, 3) == 0);
      op      = 3'($urandom_range(0, 7));
      d       = 8'($urandom);
      si      = 1'($urandom);
      amt     = 3'($urandom_range(0, 7));
      ea      = 1'($urandom);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
